// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_add_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder cell, the only arithmetic in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks one fa_cell across WIDTH-bit operands, LSB first.
// Optional macro SERIAL_SUB_EN adds a 'sub' input that turns the operation into a - b.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra counter bit so a power-of-two WIDTH never wraps to zero.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Handshake: start is only honoured in IDLE or DONE; done is a one-cycle
    // pulse after which sum/cout stay valid until the next finished operation.
    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             c;
    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    fa_cell u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry_q),
        .sum   (s),
        .carry (c)
    );

    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

`ifdef SERIAL_SUB_EN
    // Two's-complement subtract: a + ~b + 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        a_sr    <= a;
                        b_sr    <= b_load;
                        sum_sr  <= '0;
                        carry_q <= c_load;
                        cnt     <= '0;
                        state   <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    // Only WIDTH-1 partial bits are kept; the final bit goes straight to sum.
                    sum_sr  <= (WIDTH-1)'({s, sum_sr} >> 1);
                    carry_q <= c;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= {s, sum_sr};
                        cout  <= c;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random operations,
// scoreboarded against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] held = '0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci, input logic su);
        if (su)
            model = {(x >= y), x - y};
        else
            model = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            held = '0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0)
                    check("done_without_request", done, 0);
                else
                    held = exp_q.pop_front();
            end
            check("sum_cout", {cout, sum}, held);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic su);
        a     = x;
        b     = y;
        cin   = ci;
        sub   = su;
        start = 1'b1;
        exp_q.push_back(model(x, y, ci, su));
    endtask

    // Starts an operation (DUT must be in IDLE or DONE) and returns on the done cycle.
    // poke >= 0 re-asserts start with junk operands during that RUN cycle.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic su, input int poke);
        issue(x, y, ci, su);
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        for (int i = 0; i < WIDTH; i++) begin
            check("busy_in_run", busy, 1);
            check("done_in_run", done, 0);
            if (i == poke) begin
                start = 1'b1;
                a     = 8'h01;
                b     = 8'h01;
                cin   = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        #2 rst = 1'b0;
        @(negedge clk);

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, -1); idle_cycle();
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1); idle_cycle();
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, -1); idle_cycle();

        // start during RUN must be ignored
        run_op(8'h10, 8'h20, 1'b0, 1'b0, 3); idle_cycle();
        repeat (2) idle_cycle();

        // asynchronous reset in the middle of RUN
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_sum", sum, 0);
        check("async_rst_cout", cout, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        repeat (WIDTH + 2) idle_cycle();
        run_op(8'h12, 8'h34, 1'b0, 1'b0, -1); idle_cycle();

        // back-to-back: start already high in DONE
        run_op(8'h5A, 8'h3C, 1'b1, 1'b0, -1);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, -1); idle_cycle();

`ifdef SERIAL_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, -1); idle_cycle();
        run_op(8'h07, 8'h05, 1'b1, 1'b1, -1); idle_cycle();
`endif

        for (int n = 0; n < 40; n++) begin
            int poke;
            int gap;
            logic su;
            poke = int'($urandom_range(0, WIDTH));
            if (poke >= WIDTH - 1) poke = -1;
`ifdef SERIAL_SUB_EN
            su = 1'($urandom_range(0, 1));
`else
            su = 1'b0;
`endif
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), su, poke);
            gap = int'($urandom_range(0, 2));
            repeat (gap) idle_cycle();
        end
        idle_cycle();

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. Sequences a single 1-bit full-adder cell across WIDTH-bit operands, LSB first, one bit per clock, with a registered carry between bits. Sits between a requester with a start/done handshake and the full-adder datapath. Trades area (one adder cell) for latency (WIDTH cycles).

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request pulse; sampled only in IDLE or DONE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  result; held stable from done until the next accepted start
cout  output  1  final carry-out; held like sum

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry register and bit counter cleared. Takes effect immediately, including mid-RUN; the operation in flight is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge -> load A_sr=a, B_sr=b, carry_q=cin, cnt=0 -> RUN. start=0 -> stay in IDLE.
- RUN: busy=1. Each edge:
  - full-adder cell computes s=A_sr[0]^B_sr[0]^carry_q and c=majority(A_sr[0],B_sr[0],carry_q);
  - sum_sr shifts right with s inserted at the MSB;
  - A_sr and B_sr shift right;
  - carry_q<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: sum<=completed sum_sr, cout<=c, and the state moves to DONE.
  - The counter is $clog2(WIDTH)+1 bits wide, so WIDTH=power-of-2 does not wrap.
- Latency: start sampled at edge k; busy high for edges k+1..k+WIDTH; done high for exactly one cycle after edge k+WIDTH.
- DONE: done=1, busy=0, one cycle. start=1 -> load new operands and go to RUN (back-to-back, no IDLE bubble). Otherwise -> IDLE.
- start during RUN is ignored; no queuing. a/b/cin may change freely after capture.
- sum/cout update only at the DONE transition. They never show partial results.
- Arithmetic: unsigned. {cout,sum} == a+b+cin, modulo 2^(WIDTH+1).

Optional Feature:
Macro SERIAL_SUB_EN.
- Defined: adds input port sub (1 bit, captured with start). When sub=1, B_sr loads ~b and carry_q loads 1, ignoring cin. Result: sum=a-b mod 2^WIDTH, cout=1 means no borrow (a>=b). Timing is unchanged.
- Undefined: no sub port; behaviour exactly as above.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
- One sub-module, fa_cell (a, b, c -> sum, carry; purely combinational full adder), instantiated once inside serial_add_ctrl.
- The controller contains only the FSM, counter, shift registers and carry flop.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start pulse -> busy for 8 cycles, done pulse on the 9th cycle, sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start re-asserted with a=8'h01, b=8'h01 at cycle 3 of a running 8'h10+8'h20 operation -> ignored; result sum=8'h30, cout=0 with one done pulse only.
- rst asserted at cycle 4 of RUN -> busy/done/sum/cout go to 0 immediately with no clock edge; no done afterwards; a new start then completes correctly (8'h12+8'h34 -> 8'h46).
- start held high through DONE with new operands 8'h80+8'h80 -> RUN entered with no IDLE cycle; sum=8'h00, cout=1, exactly WIDTH+1 cycles after the previous done.
- SERIAL_SUB_EN defined: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0; a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
